// File: rtl/fft_frame_sequencer_if.sv
// Sample/frame bus between the pre-emphasis stage, the frame sequencer and windowed_fft.
// The master side writes audio samples and reports FFT readiness; the slave side is the sequencer.
interface fft_frame_sequencer_if #(
    parameter int BIT_WIDTH = 32
);
    logic [BIT_WIDTH-1:0] sample_in;
    logic                 sample_valid_in;
    logic                 frame_ready_in;
    logic [BIT_WIDTH-1:0] sample_out;
    logic                 sample_valid_out;
    logic                 frame_first_out;
    logic                 frame_last_out;
    logic                 busy_out;
    logic                 overrun_out;
    logic [15:0]          frame_count_out;

    modport master (
        output sample_in, sample_valid_in, frame_ready_in,
        input  sample_out, sample_valid_out, frame_first_out, frame_last_out,
               busy_out, overrun_out, frame_count_out
    );

    modport slave (
        input  sample_in, sample_valid_in, frame_ready_in,
        output sample_out, sample_valid_out, frame_first_out, frame_last_out,
               busy_out, overrun_out, frame_count_out
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for windowed_fft. Samples are written into a ring buffer; every HOP_SIZE
// samples (once WINDOW_SIZE exist) the newest WINDOW_SIZE samples are replayed oldest-first
// as one contiguous burst, gated by the FFT's ready. Read path: address -> RAM register ->
// output register, so data appears two cycles after its address is issued.
module fft_frame_sequencer #(
    parameter int BIT_WIDTH   = 32,
    parameter int WINDOW_SIZE = 400,
    parameter int HOP_SIZE    = 160,
    parameter int ADDR_WIDTH  = 9
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    fft_frame_sequencer_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = $clog2(WINDOW_SIZE + 1);
    localparam int HW    = $clog2(HOP_SIZE + 1);

    localparam logic [CW-1:0]         WIN_CNT    = CW'(WINDOW_SIZE);
    localparam logic [CW-1:0]         WIN_CNT_M1 = CW'(WINDOW_SIZE - 1);
    localparam logic [HW-1:0]         HOP_M1     = HW'(HOP_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] WIN_ADDR   = ADDR_WIDTH'(WINDOW_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_OFF   = ADDR_WIDTH'(WINDOW_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    logic [BIT_WIDTH-1:0]  ring_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [CW-1:0]         wr_cnt_r;
    logic [HW-1:0]         hop_cnt_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [ADDR_WIDTH-1:0] rd_off_r;
    logic                  drain_r;
    state_t                state_r;
    state_t                next_state_s;

    logic                  trigger_s;
    logic [ADDR_WIDTH-1:0] base_s;
    logic                  load_base_s;
    logic                  rd_en_s;
    logic                  rd_last_s;
    logic                  overrun_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;

    logic [BIT_WIDTH-1:0]  ram_q_r;
    logic                  rd_v1_r;
    logic                  rd_first1_r;
    logic                  rd_last1_r;

    logic [BIT_WIDTH-1:0]  sample_out_r;
    logic                  valid_out_r;
    logic                  first_out_r;
    logic                  last_out_r;
    logic                  busy_r;
    logic                  overrun_r;
    logic [15:0]           frame_count_r;

    // Frame trigger: the write that completes the first window, then every HOP_SIZE-th write.
    always_comb begin
        trigger_s = 1'b0;
        if (bus.sample_valid_in) begin
            if (wr_cnt_r == WIN_CNT_M1) begin
                trigger_s = 1'b1;
            end else if ((wr_cnt_r == WIN_CNT) && (hop_cnt_r == HOP_M1)) begin
                trigger_s = 1'b1;
            end else begin
                trigger_s = 1'b0;
            end
        end else begin
            trigger_s = 1'b0;
        end
    end

    // Oldest sample of the window ending with the current write (wrapping subtraction).
    assign base_s    = wr_ptr_r + ADDR_WIDTH'(1) - WIN_ADDR;
    assign rd_addr_s = base_r + rd_off_r;
    assign rd_last_s = (rd_off_r == LAST_OFF);

    // Write pointer, saturating write count and hop counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_r  <= {ADDR_WIDTH{1'b0}};
            wr_cnt_r  <= {CW{1'b0}};
            hop_cnt_r <= {HW{1'b0}};
        end else if (bus.sample_valid_in) begin
            wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
            if (wr_cnt_r != WIN_CNT) begin
                wr_cnt_r  <= wr_cnt_r + CW'(1);
                hop_cnt_r <= {HW{1'b0}};
            end else begin
                hop_cnt_r <= (hop_cnt_r == HOP_M1) ? {HW{1'b0}} : hop_cnt_r + HW'(1);
            end
        end
    end

    // Ring storage: write port always open, registered read port (contents survive reset).
    always_ff @(posedge clk_in) begin
        if (bus.sample_valid_in) begin
            ring_r[wr_ptr_r] <= bus.sample_in;
        end
        ram_q_r <= ring_r[rd_addr_s];
    end

    // Next-state logic and per-state controls for the frame FSM.
    always_comb begin
        next_state_s = state_r;
        load_base_s  = 1'b0;
        rd_en_s      = 1'b0;
        overrun_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    next_state_s = ST_ARMED;
                    load_base_s  = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                // A newer trigger supersedes the pending one; the newest window wins.
                if (trigger_s) begin
                    load_base_s = 1'b1;
                    overrun_s   = 1'b1;
                end else begin
                    load_base_s = 1'b0;
                end
                if (bus.frame_ready_in) begin
                    next_state_s = ST_STREAM;
                end else begin
                    next_state_s = ST_ARMED;
                end
            end
            ST_STREAM: begin
                rd_en_s   = 1'b1;
                overrun_s = trigger_s;
                if (rd_last_s) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                overrun_s = trigger_s;
                if (drain_r) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, latched frame base, read offset and drain timer.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r  <= ST_IDLE;
            base_r   <= {ADDR_WIDTH{1'b0}};
            rd_off_r <= {ADDR_WIDTH{1'b0}};
            drain_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (load_base_s) begin
                base_r <= base_s;
            end
            if (rd_en_s && !rd_last_s) begin
                rd_off_r <= rd_off_r + ADDR_WIDTH'(1);
            end else begin
                rd_off_r <= {ADDR_WIDTH{1'b0}};
            end
            drain_r <= (state_r == ST_DRAIN) ? ~drain_r : 1'b0;
        end
    end

    // Two-stage output pipeline matching RAM latency, plus status outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_v1_r       <= 1'b0;
            rd_first1_r   <= 1'b0;
            rd_last1_r    <= 1'b0;
            sample_out_r  <= {BIT_WIDTH{1'b0}};
            valid_out_r   <= 1'b0;
            first_out_r   <= 1'b0;
            last_out_r    <= 1'b0;
            busy_r        <= 1'b0;
            overrun_r     <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            rd_v1_r      <= rd_en_s;
            rd_first1_r  <= rd_en_s && (rd_off_r == {ADDR_WIDTH{1'b0}});
            rd_last1_r   <= rd_en_s && rd_last_s;
            sample_out_r <= rd_v1_r ? ram_q_r : {BIT_WIDTH{1'b0}};
            valid_out_r  <= rd_v1_r;
            first_out_r  <= rd_first1_r;
            last_out_r   <= rd_last1_r;
            busy_r       <= (next_state_s != ST_IDLE);
            overrun_r    <= overrun_s;
            if (rd_last1_r) begin
                frame_count_r <= frame_count_r + 16'd1;
            end
        end
    end

    assign bus.sample_out       = sample_out_r;
    assign bus.sample_valid_out = valid_out_r;
    assign bus.frame_first_out  = first_out_r;
    assign bus.frame_last_out   = last_out_r;
    assign bus.busy_out         = busy_r;
    assign bus.overrun_out      = overrun_r;
    assign bus.frame_count_out  = frame_count_r;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer: a default-size instance checked against a
// scoreboard of expected frame samples, and a small instance (W=8, H=2) checked for contiguity.
module tb_fft_frame_sequencer;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;

    always #5 clk_in = ~clk_in;

    fft_frame_sequencer_if #(.BIT_WIDTH(32)) bif ();
    fft_frame_sequencer_if #(.BIT_WIDTH(32)) sif ();

    fft_frame_sequencer #(.BIT_WIDTH(32), .WINDOW_SIZE(400), .HOP_SIZE(160), .ADDR_WIDTH(9)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bif.slave)
    );

    fft_frame_sequencer #(.BIT_WIDTH(32), .WINDOW_SIZE(8), .HOP_SIZE(2), .ADDR_WIDTH(5)) dut_small (
        .clk_in(clk_in), .rst_in(rst_in), .bus(sif.slave)
    );

    typedef struct {
        logic [31:0] data;
        logic        first;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] hist [1024];
    int          wc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          ovr_cnt = 0;
    int          out_cnt = 0;
    int          s_frames = 0;
    int          s_ovr = 0;
    int          s_k = 0;
    logic [31:0] s_base = 32'd0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic bit is_trig(input int n);
        return (n == 400) || ((n > 400) && (((n - 400) % 160) == 0));
    endfunction

    task automatic push_window(input int n);
        exp_t e;
        for (int k = 0; k < 400; k++) begin
            e.data  = hist[n - 400 + k];
            e.first = (k == 0);
            e.last  = (k == 399);
            exp_q.push_back(e);
        end
    endtask

    task automatic wr(input logic [31:0] v, input int gap, input bit push);
        bif.sample_in       = v;
        bif.sample_valid_in = 1'b1;
        hist[wc] = v;
        wc++;
        if (push && is_trig(wc)) push_window(wc);
        @(posedge clk_in); #1;
        bif.sample_valid_in = 1'b0;
        repeat (gap) begin
            @(posedge clk_in); #1;
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        bif.sample_valid_in = 1'b0;
        sif.sample_valid_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        exp_q.delete();
        wc = 0;
        check_val("rst_valid", {31'd0, bif.sample_valid_out}, 32'd0);
        check_val("rst_busy", {31'd0, bif.busy_out}, 32'd0);
        check_val("rst_count", {16'd0, bif.frame_count_out}, 32'd0);
        check_val("rst_data", bif.sample_out, 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((exp_q.size() == 0) && !bif.busy_out) break;
            @(posedge clk_in); #1;
        end
        check_val("drain_timeout", 32'(exp_q.size()), 32'd0);
        check_val("drain_busy", {31'd0, bif.busy_out}, 32'd0);
    endtask

    // Scoreboard monitor for the default-size instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                if (bif.overrun_out) ovr_cnt++;
                if (bif.sample_valid_out) begin
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_valid", {31'd0, bif.sample_valid_out}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("frame_data", bif.sample_out, e.data);
                        check_val("frame_first", {31'd0, bif.frame_first_out}, {31'd0, e.first});
                        check_val("frame_last", {31'd0, bif.frame_last_out}, {31'd0, e.last});
                        out_cnt++;
                    end
                end
            end
        end
    end

    // Contiguity monitor for the small instance.
    initial begin
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                if (sif.overrun_out) s_ovr++;
                if (sif.sample_valid_out) begin
                    if (sif.frame_first_out) begin
                        s_base = sif.sample_out;
                        s_k = 0;
                        check_val("t4_align", {31'd0, sif.sample_out[0]}, 32'd1);
                        if (s_frames == 0) check_val("t4_first_frame", sif.sample_out, 32'd1);
                    end else begin
                        s_k++;
                        check_val("t4_contig", sif.sample_out, s_base + 32'(s_k));
                    end
                    if (sif.frame_last_out) begin
                        check_val("t4_len", 32'(s_k), 32'd7);
                        s_frames++;
                    end
                end
            end
        end
    end

    initial begin
        int ovr0;
        bif.sample_in = 32'd0; bif.sample_valid_in = 1'b0; bif.frame_ready_in = 1'b0;
        sif.sample_in = 32'd0; sif.sample_valid_in = 1'b0; sif.frame_ready_in = 1'b0;

        // T1: first frame only after the 400th write.
        do_reset();
        bif.frame_ready_in = 1'b1;
        ovr0 = ovr_cnt;
        for (int i = 1; i <= 399; i++) wr(32'(i), 2, 1'b1);
        repeat (5) @(posedge clk_in);
        #1;
        check_val("t1_no_frame_busy", {31'd0, bif.busy_out}, 32'd0);
        check_val("t1_no_frame_count", {16'd0, bif.frame_count_out}, 32'd0);
        wr(32'd400, 2, 1'b1);
        wait_idle(1000);
        check_val("t1_count", {16'd0, bif.frame_count_out}, 32'd1);

        // T2: hops 2..4, fourth frame wraps the ring mid-frame.
        for (int i = 401; i <= 880; i++) wr(32'(i), 2, 1'b1);
        wait_idle(1000);
        check_val("t2_count", {16'd0, bif.frame_count_out}, 32'd4);
        check_val("t2_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);

        // T3: FFT not ready; newer triggers supersede, then the newest window streams.
        do_reset();
        bif.frame_ready_in = 1'b0;
        ovr0 = ovr_cnt;
        for (int i = 0; i < 720; i++) wr(32'h0001_0000 + 32'(i), 0, 1'b0);
        repeat (3) @(posedge clk_in);
        #1;
        check_val("t3_overruns", 32'(ovr_cnt - ovr0), 32'd2);
        push_window(720);
        bif.frame_ready_in = 1'b1;
        wait_idle(1000);
        check_val("t3_count", {16'd0, bif.frame_count_out}, 32'd1);

        // T4: small instance, write every cycle.
        sif.frame_ready_in = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            sif.sample_in = 32'(i);
            sif.sample_valid_in = 1'b1;
            @(posedge clk_in); #1;
        end
        sif.sample_valid_in = 1'b0;
        repeat (40) @(posedge clk_in);
        #1;
        check_val("t4_idle", {31'd0, sif.busy_out}, 32'd0);
        check_val("t4_trigger_acct", 32'(s_frames + s_ovr), 32'd47);
        check_val("t4_overrun_seen", {31'd0, (s_ovr > 0)}, 32'd1);
        check_val("t4_frame_count", {16'd0, sif.frame_count_out}, 32'(s_frames));

        // T5: writes during every STREAM cycle leave the frame intact.
        do_reset();
        bif.frame_ready_in = 1'b1;
        ovr0 = ovr_cnt;
        for (int i = 0; i < 399; i++) wr(32'hF000_0000 + 32'(i), 1, 1'b1);
        wr(32'hF000_0000 + 32'd399, 0, 1'b1);
        for (int i = 400; i < 800; i++) wr(32'h0A00_0000 + 32'(i), 0, 1'b0);
        wait_idle(1000);
        check_val("t5_count", {16'd0, bif.frame_count_out}, 32'd1);
        check_val("t5_overruns", 32'(ovr_cnt - ovr0), 32'd2);

        // T6: reset mid-frame, then a full fresh window is needed.
        do_reset();
        bif.frame_ready_in = 1'b1;
        out_cnt = 0;
        for (int i = 0; i < 400; i++) wr(32'h0300_0000 + 32'(i), 0, 1'b1);
        for (int i = 0; i < 2000 && out_cnt < 200; i++) begin
            @(posedge clk_in); #1;
        end
        check_val("t6_reach200", 32'(out_cnt), 32'd200);
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        check_val("t6_rst_valid", {31'd0, bif.sample_valid_out}, 32'd0);
        check_val("t6_rst_busy", {31'd0, bif.busy_out}, 32'd0);
        check_val("t6_rst_data", bif.sample_out, 32'd0);
        check_val("t6_rst_count", {16'd0, bif.frame_count_out}, 32'd0);
        check_val("t6_rst_flags", {30'd0, bif.frame_first_out, bif.frame_last_out}, 32'd0);
        rst_in = 1'b0;
        exp_q.delete();
        wc = 0;
        for (int i = 0; i < 399; i++) wr(32'h0400_0000 + 32'(i), 0, 1'b1);
        repeat (10) @(posedge clk_in);
        #1;
        check_val("t6_no_frame_busy", {31'd0, bif.busy_out}, 32'd0);
        wr(32'h0400_0000 + 32'd399, 0, 1'b1);
        wait_idle(1000);
        check_val("t6_count", {16'd0, bif.frame_count_out}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
